// File: rtl/alu_sched_pkg.sv
// Shared types and constants for the ALU operation scheduler.
// Holds the FSM state encoding, default datapath widths and a saturating
// increment helper used by the optional per-requester statistics counters.
package alu_sched_pkg;

    localparam int ALU_W     = 8;
    localparam int ALU_SEL_W = 4;
    localparam int CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (value == {CNT_W{1'b1}}) ? value : value + 1'b1;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter for the ALU scheduler.
// A lone request is always granted. When both requesters ask at once, the
// one that did not win the previous accepted contest is granted. The
// remembered winner only moves when the caller signals an acceptance, so a
// grant that is never taken does not disturb fairness.
import alu_sched_pkg::*;

module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       en,
    output logic [1:0] gnt
);

    logic last_grant;

    // Grant decision from the current requests and the last accepted winner.
    always_comb begin
        gnt = 2'b00;
        case (req)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = last_grant ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    // Remember who won; reset favours requester 0 in the first contest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= 1'b1;
        end else if (en && (gnt != 2'b00)) begin
            last_grant <= gnt[1];
        end
    end

endmodule

// File: rtl/alu_op_scheduler.sv
// ALU operation scheduler: shares one combinational ALU between two
// requesters. An op is accepted by valid/ready, its operands are held on the
// ALU inputs for EXEC_CYC cycles, then result and carry are captured and
// returned on a valid/ready response port tagged with the requester id.
// Only one op is in flight; the FSM runs IDLE -> EXEC -> RESP -> IDLE.
// Optional feature macro: ALU_SCHED_STATS_EN adds saturating 16-bit
// completed-response counters op_cnt0/op_cnt1.
import alu_sched_pkg::*;

module alu_op_scheduler #(
    parameter int WIDTH    = ALU_W,
    parameter int SEL_W    = ALU_SEL_W,
    parameter int EXEC_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [SEL_W-1:0] req0_sel,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [SEL_W-1:0] req1_sel,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [SEL_W-1:0] alu_sel,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_carryout,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_result,
    output logic             rsp_carry,
    output logic             busy
`ifdef ALU_SCHED_STATS_EN
    ,
    output logic [CNT_W-1:0] op_cnt0,
    output logic [CNT_W-1:0] op_cnt1
`endif
);

    // The exec counter is four bits wide, enough for the 1..15 cycle range.
    localparam logic [3:0] EXEC_LOAD = 4'(EXEC_CYC - 1);

    state_t     state;
    logic [3:0] exec_cnt;
    logic       op_id;
    logic [1:0] gnt;
    logic       idle;
    logic       accept;
    logic       rsp_done;

    rr_arb2 u_arb (
        .clk   (clk),
        .rst_n (rst_n),
        .req   ({req1_valid, req0_valid}),
        .en    (accept),
        .gnt   (gnt)
    );

    // Readies are gated by reset so every output reads 0 while reset is held.
    always_comb begin
        idle       = (state == IDLE);
        req0_ready = rst_n && idle && gnt[0];
        req1_ready = rst_n && idle && gnt[1];
        accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);
        rsp_done   = rsp_valid && rsp_ready;
        busy       = (state != IDLE);
    end

    // Main FSM with operand latch, exec countdown and response capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            exec_cnt   <= 4'd0;
            op_id      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_sel    <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_a    <= gnt[1] ? req1_a   : req0_a;
                        alu_b    <= gnt[1] ? req1_b   : req0_b;
                        alu_sel  <= gnt[1] ? req1_sel : req0_sel;
                        op_id    <= gnt[1];
                        exec_cnt <= EXEC_LOAD;
                        state    <= EXEC;
                    end
                end
                EXEC: begin
                    if (exec_cnt == 4'd0) begin
                        rsp_result <= alu_result;
                        rsp_carry  <= alu_carryout;
                        rsp_id     <= op_id;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else begin
                        exec_cnt <= exec_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_done) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef ALU_SCHED_STATS_EN
    // Count completed response handshakes per requester, saturating at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_cnt0 <= '0;
            op_cnt1 <= '0;
        end else if (rsp_done) begin
            if (rsp_id) begin
                op_cnt1 <= sat_inc(op_cnt1);
            end else begin
                op_cnt0 <= sat_inc(op_cnt0);
            end
        end
    end
`endif

endmodule
